// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MULT/MULTU sequencer that time-shares one external 32-bit adder.
// Sign-magnitude conversion, 32 shift-add steps, then 64-bit negation of the product.
module mul_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_ITER   = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_mag_q, a_mag_d;
  logic [W-1:0]    hi_w_q, hi_w_d;
  logic [W-1:0]    lo_w_q, lo_w_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic            neg_q, neg_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sa_c, sb_c;

  // Next-state, datapath updates and adder operand muxing
  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    hi_w_d  = hi_w_q;
    lo_w_d  = lo_w_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    cy_d    = cy_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    sa_c    = sgn_q & a_mag_q[W-1];
    sb_c    = sgn_q & lo_w_q[W-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_mag_d = op_a;
          lo_w_d  = op_b;
          hi_w_d  = '0;
          cnt_d   = '0;
          cy_d    = 1'b0;
          sgn_d   = is_signed;
          neg_d   = is_signed & (op_a[W-1] ^ op_b[W-1]);
          state_d = is_signed ? S_NEG_A : S_ITER;
        end
      end
      S_NEG_A: begin
        add_a   = sa_c ? ~a_mag_q : a_mag_q;
        add_cin = sa_c;
        a_mag_d = add_sum;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        add_a   = sb_c ? ~lo_w_q : lo_w_q;
        add_cin = sb_c;
        lo_w_d  = add_sum;
        state_d = S_ITER;
      end
      S_ITER: begin
        // Partial product accumulates in hi_w; multiplier bits shift out of lo_w
        add_a  = hi_w_q;
        add_b  = lo_w_q[0] ? a_mag_q : '0;
        hi_w_d = {add_cout, add_sum[W-1:1]};
        lo_w_d = {add_sum[0], lo_w_q[W-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = sgn_q ? S_NEG_LO : S_DONE;
        end
      end
      S_NEG_LO: begin
        add_a   = neg_q ? ~lo_w_q : lo_w_q;
        add_cin = neg_q;
        lo_w_d  = add_sum;
        cy_d    = add_cout;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        add_a   = neg_q ? ~hi_w_q : hi_w_q;
        add_cin = neg_q & cy_q;
        hi_w_d  = add_sum;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    hi_d = hi_q;
    lo_d = lo_q;
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      hi_d = hi_w_d;
      lo_d = lo_w_d;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_mag_q <= '0;
      hi_w_q  <= '0;
      lo_w_q  <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      cy_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      hi_w_q  <= hi_w_d;
      lo_w_q  <= lo_w_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      cy_q    <= cy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural 32-bit adder attached.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  mul_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_signed(is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result checker: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        chk("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Starts an op in the current (IDLE) cycle and checks busy/done per cycle;
  // returns in the first IDLE cycle after DONE.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat;
    lat = sgn ? 37 : 33;
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      chk("busy", 64'(busy), 64'(c <= lat));
      chk("done", 64'(done), 64'(c == lat));
      if (c <= lat) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("idle_adder", {add_a, add_b, add_cin}, 65'd0);
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    chk("idle_adder2", {add_a, add_b, add_cin}, 65'd0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);

    // Start re-asserted while busy (mid-ITER and in DONE) must be ignored
    d0 = done_cnt;
    start = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd3;
    exp_q.push_back(64'd6);
    tick();
    for (int c = 1; c <= 33; c++) begin
      start = (c == 5) || (c == 33);
      is_signed = 1'b1; op_a = 32'd9; op_b = 32'd9;
      #1;
      chk("rt_busy", 64'(busy), 64'd1);
      chk("rt_done", 64'(done), 64'(c == 33));
      tick();
    end
    start = 1'b0;
    chk("rt_busy_idle", 64'(busy), 64'd0);
    chk("rt_done_count", 64'(done_cnt - d0), 64'd1);
    run_op(1'b0, 32'd10, 32'd11, 64'd110);

    // Synchronous reset in the middle of a signed operation
    d0 = done_cnt;
    start = 1'b1; is_signed = 1'b1; op_a = 32'h1234_5678; op_b = 32'hFFFF_FFF9;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) rst_n = 1'b0;
      tick();
    end
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_hilo", {hi, lo}, 64'd0);
    chk("ab_adder", {add_a, add_b, add_cin}, 65'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
    chk("ab_busy_late", 64'(busy), 64'd0);
    run_op(1'b1, 32'd4, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(rs, ra, rb, model(rs, ra, rb));
    end

    tick(); tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply sequencer that executes MIPS MULT/MULTU by time-sharing one external 32-bit carry-lookahead adder, built from the 4-bit P/G lookahead units, instead of instantiating a dedicated array multiplier. It latches two operands on a start pulse, then drives the adder's operand and carry-in ports every cycle: sign-magnitude conversion, 32 shift-add iterations, and 64-bit result negation. It returns HI/LO with a one-cycle done pulse. It sits beside the ALU in the execute stage and holds the pipeline via busy.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  in  32  multiplicand; sampled with start.
- op_b  in  32  multiplier; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  32  product[63:32]; held until next done.
- lo  out  32  product[31:0]; held until next done.
- add_a  out  32  adder operand A.
- add_b  out  32  adder operand B.
- add_cin  out  1  adder carry-in.
- add_sum  in  32  adder sum; combinational, same cycle.
- add_cout  in  1  adder carry-out, same cycle.

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE.
- IDLE: add_a, add_b and add_cin are 0.
- Accepting start in IDLE:
  - Latch operands.
  - Compute neg_res = is_signed & (op_a[31] ^ op_b[31]).
  - Clear hi_w to 0 and the iteration counter cnt (6 bits) to 0.
  - Next state is NEG_A if is_signed, else ITER, with a_mag = op_a and lo_w = op_b.
- NEG_A: add_a = sa ? ~a : a, add_b = 0, add_cin = sa, where sa = is_signed & a[31]; a_mag <= add_sum.
- NEG_B: same form on b; lo_w <= add_sum.
- ITER, each cycle:
  - add_a = hi_w, add_b = lo_w[0] ? a_mag : 0, add_cin = 0.
  - hi_w <= {add_cout, add_sum[31:1]}; lo_w <= {add_sum[0], lo_w[31:1]}; cnt++.
  - Leave after the 32nd iteration (cnt == 31): to NEG_LO if is_signed, else DONE.
- NEG_LO: add_a = neg_res ? ~lo_w : lo_w, add_b = 0, add_cin = neg_res; lo_w <= add_sum, cy <= add_cout.
- NEG_HI: add_a = neg_res ? ~hi_w : hi_w, add_b = 0, add_cin = neg_res & cy; hi_w <= add_sum.
- Output registers: hi <= hi_w and lo <= lo_w on the edge entering DONE.
- DONE: done = 1; next state IDLE unconditionally.
- start is ignored while busy, including in DONE; operands are not re-latched.
- Magnitude of 0x80000000 is 0x80000000 unsigned; no special case needed.
- Signed path runs NEG_A, NEG_B, NEG_LO and NEG_HI even for positive operands, so latency is fixed.

## Timing
- Cycle 0 is the cycle in which start = 1 in IDLE.
- Unsigned: ITER in cycles 1–32; DONE (done = 1) in cycle 33; IDLE in cycle 34; busy high in cycles 1–33.
- Signed: NEG_A in cycle 1, NEG_B in 2, ITER in 3–34, NEG_LO in 35, NEG_HI in 36, DONE in 37; busy high in cycles 1–37.
- Earliest back-to-back start is in the first IDLE cycle after DONE.
- The adder path is combinational within one cycle; no adder output is registered inside the adder.
- Reset, checked at any clock edge including mid-operation:
  - State returns to IDLE.
  - busy, done, hi, lo, the internal working registers and cnt all become 0.
  - No done pulse is emitted for the aborted operation.

## Test plan
- MULTU 7 × 6: start in cycle 0 -> done only in cycle 33; hi = 0x00000000, lo = 0x0000002A; busy high in cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT −3 × 5 (0xFFFFFFFD, 0x00000005) -> done in cycle 37; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULT with both operands 0x80000000 -> hi = 0x40000000, lo = 0x00000000. MULT −1 × −1 -> hi = 0, lo = 1.
- Start re-asserted with new operands in cycles 5 and 33 of a MULTU 2 × 3:
  - Result is hi = 0, lo = 6, with exactly one done pulse.
  - The next start in cycle 34 is accepted normally.
- rst_n low in cycle 10 of a signed operation:
  - From the next cycle: busy = 0, hi = lo = 0, IDLE, no done.
  - A subsequent MULT 4 × −2 returns hi = 0xFFFFFFFF, lo = 0xFFFFFFF8.
